iq_merge: RTL and testbench

IQ_MERGE -- requirements
Module: iq_merge

---
 rtl/iq_pkg.sv | 25 ++
 rtl/iq_merge_bit_timer.sv | 49 ++++
 rtl/iq_merge.sv | 126 ++++++++++++
 tb/tb_iq_merge.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// iq_pkg: shared definitions for the IQ merge serializer.
// Holds the FSM state encoding and a constant ceil(log2) helper used to size
// the sample and bit-index counters.
package iq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Number of bits needed to count 0..n-1 (ceil(log2(n))), for n >= 2.
  function automatic int ceil_log2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_merge_bit_timer.sv
// bit_timer: per-symbol timing for the IQ serializer.
// Counts SAMPLE cycles per bit and 2*BPC bits per symbol.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   clear        return both counters to zero (load, resync, leaving RUN)
//   run          advance the counters this cycle
//   last_sample  sample counter is at SAMPLE-1
//   last_bit     bit index is at 2*BPC-1
module bit_timer
  import iq_pkg::*;
#(
  parameter int SAMPLE = 100,
  parameter int BPC    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic last_sample,
  output logic last_bit
);

  localparam int SW = ceil_log2(SAMPLE);
  localparam int BW = ceil_log2(2 * BPC);
  localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * BPC - 1);

  logic [SW-1:0] smp;
  logic [BW-1:0] bidx;

  assign last_sample = (smp == SMP_LAST);
  assign last_bit    = (bidx == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      smp  <= '0;
      bidx <= '0;
    end else if (run) begin
      if (last_sample) begin
        smp  <= '0;
        bidx <= last_bit ? '0 : bidx + 1'b1;
      end else begin
        smp <= smp + 1'b1;
      end
    end
  end

endmodule

// File: rtl/iq_merge.sv
// iq_merge: serializes decided I/Q symbol bits into one demodulated bit stream.
// Each symbol yields 2*BPC bits, each held SAMPLE cycles, MSB first; Q bits
// lead unless IQ_FIRST=1.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   en          level enable; low returns to IDLE with outputs cleared
//   sym_valid   one-cycle pulse: new symbol on sample_d_I / sample_d_Q
//   sample_d_I  decided I bits
//   sample_d_Q  decided Q bits
//   demo_ser_o  serial bit stream
//   ser_valid   demo_ser_o carries symbol data
//   bit_strobe  first cycle of each output bit
//   sync_err    one-cycle pulse on resync or underrun
//
// state | meaning
// IDLE  | disabled, outputs low
// ALIGN | enabled, waiting for the first/next sym_valid
// RUN   | shifting out the loaded symbol
module iq_merge
  import iq_pkg::*;
#(
  parameter int SAMPLE   = 100,
  parameter int BPC      = 1,
  parameter int IQ_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           sym_valid,
  input  logic [BPC-1:0] sample_d_I,
  input  logic [BPC-1:0] sample_d_Q,
  output logic           demo_ser_o,
  output logic           ser_valid,
  output logic           bit_strobe,
  output logic           sync_err
);

  localparam int FW = 2 * BPC;

  state_t        state;
  logic [FW-1:0] sreg;
  logic [FW-1:0] load_vec;
  logic          last_sample;
  logic          last_bit;
  logic          frame_end;
  logic          timer_clear;
  logic          timer_run;

  assign load_vec  = (IQ_FIRST != 0) ? {sample_d_I, sample_d_Q}
                                     : {sample_d_Q, sample_d_I};
  assign frame_end = last_sample && last_bit;

  // Counters sit at zero outside RUN and restart on every (re)load.
  assign timer_clear = !en || (state != RUN) || sym_valid;
  assign timer_run   = en && (state == RUN);

  bit_timer #(
    .SAMPLE(SAMPLE),
    .BPC   (BPC)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (timer_clear),
    .run        (timer_run),
    .last_sample(last_sample),
    .last_bit   (last_bit)
  );

  // The shift register MSB is the serial output, so it is cleared whenever
  // the stream must read 0.
  assign demo_ser_o = sreg[FW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      ser_valid  <= 1'b0;
      bit_strobe <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      bit_strobe <= 1'b0;
      sync_err   <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        sreg      <= '0;
        ser_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ALIGN;
          ALIGN: begin
            if (sym_valid) begin
              sreg       <= load_vec;
              ser_valid  <= 1'b1;
              bit_strobe <= 1'b1;
              state      <= RUN;
            end
          end
          RUN: begin
            if (sym_valid) begin
              // On the frame's last cycle this is a seamless reload;
              // anywhere else it abandons the current symbol.
              sreg       <= load_vec;
              bit_strobe <= 1'b1;
              sync_err   <= !frame_end;
            end else if (frame_end) begin
              sreg      <= '0;
              ser_valid <= 1'b0;
              sync_err  <= 1'b1;
              state     <= ALIGN;
            end else if (last_sample) begin
              sreg       <= sreg << 1;
              bit_strobe <= 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            sreg      <= '0;
            ser_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iq_merge.sv
module tb_iq_merge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, sym_valid;
  logic [1:0] sample_d_I, sample_d_Q;
  logic       demo_ser_o, ser_valid, bit_strobe, sync_err;

  logic       en1, sv1;
  logic [0:0] i1, q1;
  logic       d1_ser, d1_valid, d1_strobe, d1_err;

  iq_merge #(.SAMPLE(4), .BPC(2), .IQ_FIRST(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sym_valid (sym_valid),
    .sample_d_I(sample_d_I),
    .sample_d_Q(sample_d_Q),
    .demo_ser_o(demo_ser_o),
    .ser_valid (ser_valid),
    .bit_strobe(bit_strobe),
    .sync_err  (sync_err)
  );

  iq_merge #(.SAMPLE(100), .BPC(1), .IQ_FIRST(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .en        (en1),
    .sym_valid (sv1),
    .sample_d_I(i1),
    .sample_d_Q(q1),
    .demo_ser_o(d1_ser),
    .ser_valid (d1_valid),
    .bit_strobe(d1_strobe),
    .sync_err  (d1_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] i;
    logic [1:0] q;
    logic [3:0] pat;  // expected serial bits, first bit in pat[3]
  } sym_t;

  sym_t tbl[4];

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic d, input logic v,
                           input logic s, input logic e);
    check({tag, ".demo"}, demo_ser_o, d);
    check({tag, ".valid"}, ser_valid, v);
    check({tag, ".strobe"}, bit_strobe, s);
    check({tag, ".sync_err"}, sync_err, e);
  endtask

  task automatic load(input int idx);
    sample_d_I = tbl[idx].i;
    sample_d_Q = tbl[idx].q;
    sym_valid  = 1'b1;
    step();
    sym_valid  = 1'b0;
  endtask

  task automatic run_frame(input int idx, input int from, input int upto);
    for (int c = from; c <= upto; c++) begin
      check_out($sformatf("sym%0d.c%0d", idx, c), tbl[idx].pat[3 - c / 4],
                1'b1, (c % 4) == 0, 1'b0);
      step();
    end
  endtask

  task automatic check_underrun(input string tag);
    check_out({tag, ".underrun"}, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check_out({tag, ".align"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // pattern is {Q, I}, MSB first
    tbl[0] = '{i: 2'b10, q: 2'b01, pat: 4'b0110};
    tbl[1] = '{i: 2'b11, q: 2'b00, pat: 4'b0011};
    tbl[2] = '{i: 2'b00, q: 2'b11, pat: 4'b1100};
    tbl[3] = '{i: 2'b01, q: 2'b10, pat: 4'b1001};

    rst = 1'b1; en = 1'b0; sym_valid = 1'b0;
    sample_d_I = '0; sample_d_Q = '0;
    en1 = 1'b0; sv1 = 1'b0; i1 = '0; q1 = '0;
    step();
    step();
    check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.d1_valid", d1_valid, 1'b0);

    // enable, wait in ALIGN with junk data, first symbol
    rst = 1'b0; en = 1'b1;
    sample_d_I = 2'b11; sample_d_Q = 2'b11;
    step();
    for (int c = 0; c < 8; c++) begin
      check_out("align_wait", 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    load(0);
    run_frame(0, 0, 15);
    check_underrun("first");

    // table of symbols, each followed by underrun and restart
    for (int k = 1; k < 4; k++) begin
      load(k);
      run_frame(k, 0, 15);
      check_underrun($sformatf("tbl%0d", k));
    end

    // back-to-back: three symbols, 48 continuous cycles
    load(0);
    for (int c = 0; c < 48; c++) begin
      check_out($sformatf("b2b.c%0d", c), tbl[c / 16].pat[3 - (c % 16) / 4],
                1'b1, (c % 4) == 0, 1'b0);
      if (c == 15 || c == 31) begin
        sample_d_I = tbl[c / 16 + 1].i;
        sample_d_Q = tbl[c / 16 + 1].q;
        sym_valid  = 1'b1;
      end
      step();
      sym_valid = 1'b0;
    end
    check_underrun("b2b");

    // resync: sym_valid 6 cycles into a frame
    load(1);
    run_frame(1, 0, 4);
    check_out("pre_resync", tbl[1].pat[2], 1'b1, 1'b0, 1'b0);
    load(2);
    check_out("resync", tbl[2].pat[3], 1'b1, 1'b1, 1'b1);
    step();
    run_frame(2, 1, 15);
    check_underrun("resync");

    // en dropped mid-frame
    load(2);
    run_frame(2, 0, 4);
    en = 1'b0;
    step();
    check_out("en_drop", 1'b0, 1'b0, 1'b0, 1'b0);
    sym_valid = 1'b1;
    step();
    check_out("sv_en_low", 1'b0, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    step();
    check_out("sv_in_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    sym_valid = 1'b0;

    // reset mid-frame
    load(2);
    run_frame(2, 0, 4);
    rst = 1'b1;
    step();
    check_out("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_out("rst_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // sym_valid and en falling on the same edge
    load(0);
    run_frame(0, 0, 2);
    sample_d_I = tbl[3].i;
    sample_d_Q = tbl[3].q;
    sym_valid = 1'b1;
    en = 1'b0;
    step();
    sym_valid = 1'b0;
    check_out("sv_en_fall", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("sv_en_fall2", 1'b0, 1'b0, 1'b0, 1'b0);

    // BPC=1, SAMPLE=100, IQ_FIRST=1, I=1, Q=0
    en1 = 1'b1;
    step();
    i1 = 1'b1; q1 = 1'b0; sv1 = 1'b1;
    step();
    sv1 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      check($sformatf("d1.demo.c%0d", c), d1_ser, c < 100);
      check($sformatf("d1.valid.c%0d", c), d1_valid, 1'b1);
      check($sformatf("d1.strobe.c%0d", c), d1_strobe, (c == 0) || (c == 100));
      check($sformatf("d1.err.c%0d", c), d1_err, 1'b0);
      step();
    end
    check("d1.underrun.err", d1_err, 1'b1);
    check("d1.underrun.valid", d1_valid, 1'b0);
    check("d1.underrun.demo", d1_ser, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
